// File: rtl/enemy_formation_if.sv
// Pixel-pipeline bus between the enemy formation controller and its driver:
// frame/start/collision strobes and the VGA pixel in, draw data and wave status out.
interface enemy_formation_if #(
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 6
);
    localparam int N     = NUM_ROWS * NUM_COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(N + 1);

    logic             startOfFrame;
    logic             start;
    logic             collision;
    logic [10:0]      pixelX;
    logic [10:0]      pixelY;
    logic             drawingRequest;
    logic [10:0]      offsetX;
    logic [10:0]      offsetY;
    logic [IDX_W-1:0] enemyIndex;
    logic [CNT_W-1:0] aliveCount;
    logic             cleared;
    logic             landed;

    modport master (
        output startOfFrame, start, collision, pixelX, pixelY,
        input  drawingRequest, offsetX, offsetY, enemyIndex, aliveCount, cleared, landed
    );

    modport slave (
        input  startOfFrame, start, collision, pixelX, pixelY,
        output drawingRequest, offsetX, offsetY, enemyIndex, aliveCount, cleared, landed
    );
endinterface

// File: rtl/enemy_formation_ctrl.sv
// Moves a NUM_ROWS x NUM_COLS enemy formation in fixed point once per frame,
// bounces and steps down at screen edges, tracks kills, and draws live enemies.
module enemy_formation_ctrl #(
    parameter int NUM_COLS               = 6,
    parameter int NUM_ROWS               = 3,
    parameter int INITIAL_X              = 40,
    parameter int INITIAL_Y              = 40,
    parameter int OBJECT_WIDTH_X         = 30,
    parameter int OBJECT_HEIGHT_Y        = 30,
    parameter int GAP_X                  = 10,
    parameter int GAP_Y                  = 10,
    parameter int X_SPEED                = 64,
    parameter int SPEEDUP_STEP           = 8,
    parameter int STEP_DOWN_Y            = 16,
    parameter int SCREEN_WIDTH           = 640,
    parameter int BOTTOM_LIMIT           = 440,
    parameter int FIXED_POINT_MULTIPLIER = 64
) (
    input logic              clk,
    input logic              reset,
    enemy_formation_if.slave bus
);

    localparam int N       = NUM_ROWS * NUM_COLS;
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W   = $clog2(N + 1);
    localparam int PITCH_X = OBJECT_WIDTH_X + GAP_X;
    localparam int PITCH_Y = OBJECT_HEIGHT_Y + GAP_Y;
    localparam int FPM     = FIXED_POINT_MULTIPLIER;

    localparam logic signed [31:0] X_RESET = 32'(INITIAL_X * FPM);
    localparam logic signed [31:0] Y_RESET = 32'(INITIAL_Y * FPM);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MOVE    = 2'd1;
    localparam logic [1:0] ST_CLEARED = 2'd2;
    localparam logic [1:0] ST_LANDED  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic signed [31:0] x_q, x_d;
    logic signed [31:0] y_q, y_d;
    logic               dir_left_q, dir_left_d;
    logic [N-1:0]       alive_q, alive_d;
    logic [CNT_W-1:0]   alive_cnt_q, alive_cnt_d;

    logic               draw_q, draw_d;
    logic [10:0]        off_x_q, off_x_d;
    logic [10:0]        off_y_q, off_y_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    // ------------------------------------------------------------------
    // Drawing: locate the pixel inside the formation grid
    // ------------------------------------------------------------------
    logic signed [31:0] pos_x_px, pos_y_px, rel_x, rel_y;
    logic               col_hit, row_hit;
    int                 col_sel, row_sel, in_x, in_y;
    logic [IDX_W-1:0]   flat_idx;

    assign pos_x_px = x_q / FPM;
    assign pos_y_px = y_q / FPM;
    assign rel_x    = $signed({{21{bus.pixelX[10]}}, bus.pixelX}) - pos_x_px;
    assign rel_y    = $signed({{21{bus.pixelY[10]}}, bus.pixelY}) - pos_y_px;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        col_hit = 1'b0;
        row_hit = 1'b0;
        col_sel = 0;
        row_sel = 0;
        in_x    = 0;
        in_y    = 0;
        // Range compares per column/row replace the division and modulo.
        for (int c = 0; c < NUM_COLS; c++) begin
            if (rel_x >= c * PITCH_X && rel_x < c * PITCH_X + OBJECT_WIDTH_X) begin
                col_hit = 1'b1;
                col_sel = c;
                in_x    = rel_x - c * PITCH_X;
            end
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (rel_y >= r * PITCH_Y && rel_y < r * PITCH_Y + OBJECT_HEIGHT_Y) begin
                row_hit = 1'b1;
                row_sel = r;
                in_y    = rel_y - r * PITCH_Y;
            end
        end
        flat_idx = IDX_W'(row_sel * NUM_COLS + col_sel);

        draw_d  = 1'b0;
        off_x_d = '0;
        off_y_d = '0;
        idx_d   = '0;
        if (col_hit && row_hit && alive_q[flat_idx]) begin
            draw_d  = 1'b1;
            off_x_d = 11'(in_x);
            off_y_d = 11'(in_y);
            idx_d   = flat_idx;
        end
    end

    // ------------------------------------------------------------------
    // Formation extent over live enemies only
    // ------------------------------------------------------------------
    logic [NUM_COLS-1:0] col_any;
    logic [NUM_ROWS-1:0] row_any;
    int                  l_col, r_col, b_row;

    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                col_any[c] = col_any[c] | alive_q[r * NUM_COLS + c];
                row_any[r] = row_any[r] | alive_q[r * NUM_COLS + c];
            end
        end
        l_col = 0;
        r_col = 0;
        b_row = 0;
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (col_any[c]) l_col = c;
        end
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_any[c]) r_col = c;
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_any[r]) b_row = r;
        end
    end

    // ------------------------------------------------------------------
    // Motion and kill decode
    // ------------------------------------------------------------------
    logic signed [31:0] speed, x_next, y_step;
    logic               hit_right, hit_left, lands;
    logic               kill, last_kill;

    assign speed     = 32'(X_SPEED) + (32'(N) - 32'(alive_cnt_q)) * 32'(SPEEDUP_STEP);
    assign x_next    = dir_left_q ? (x_q - speed) : (x_q + speed);
    assign y_step    = y_q + 32'(STEP_DOWN_Y * FPM);
    assign hit_right = !dir_left_q &&
                       (x_next / FPM + r_col * PITCH_X + OBJECT_WIDTH_X > SCREEN_WIDTH);
    assign hit_left  = dir_left_q && (x_next / FPM + l_col * PITCH_X < 0);
    assign lands     = (y_step / FPM + b_row * PITCH_Y + OBJECT_HEIGHT_Y >= BOTTOM_LIMIT);

    // The alive check keeps a stale collision from decrementing the count twice.
    assign kill      = (state_q == ST_MOVE) && bus.collision && draw_q && alive_q[idx_q];
    assign last_kill = kill && (alive_cnt_q == CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_left_d  = dir_left_q;
        alive_d     = alive_q;
        alive_cnt_d = alive_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_MOVE;
            end
            ST_MOVE: begin
                if (kill) begin
                    alive_d[idx_q] = 1'b0;
                    alive_cnt_d    = alive_cnt_q - CNT_W'(1);
                end
                // Movement uses the pre-kill mask and speed on a shared edge.
                if (bus.startOfFrame) begin
                    if (hit_right || hit_left) begin
                        dir_left_d = !dir_left_q;
                        y_d        = y_step;
                        if (lands) state_d = ST_LANDED;
                    end else begin
                        x_d = x_next;
                    end
                end
                if (last_kill) state_d = ST_CLEARED;
            end
            ST_CLEARED, ST_LANDED: begin
                if (bus.start) begin
                    state_d     = ST_MOVE;
                    x_d         = X_RESET;
                    y_d         = Y_RESET;
                    dir_left_d  = 1'b0;
                    alive_d     = '1;
                    alive_cnt_d = CNT_W'(N);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x_q         <= X_RESET;
            y_q         <= Y_RESET;
            dir_left_q  <= 1'b0;
            alive_q     <= '1;
            alive_cnt_q <= CNT_W'(N);
            draw_q      <= 1'b0;
            off_x_q     <= '0;
            off_y_q     <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_left_q  <= dir_left_d;
            alive_q     <= alive_d;
            alive_cnt_q <= alive_cnt_d;
            draw_q      <= draw_d;
            off_x_q     <= off_x_d;
            off_y_q     <= off_y_d;
            idx_q       <= idx_d;
        end
    end

    assign bus.drawingRequest = draw_q;
    assign bus.offsetX        = off_x_q;
    assign bus.offsetY        = off_y_q;
    assign bus.enemyIndex     = idx_q;
    assign bus.aliveCount     = alive_cnt_q;
    assign bus.cleared        = (state_q == ST_CLEARED);
    assign bus.landed         = (state_q == ST_LANDED);

endmodule

// File: doc/enemy_formation_ctrl.md
Name: enemy_formation_ctrl

Overview:
Parametrised successor of the single-enemy mover. It moves a NUM_ROWS x NUM_COLS formation of enemies horizontally in fixed point, once per frame. When the formation hits a screen edge it bounces and steps down one notch. The block keeps a per-enemy alive mask, removes an enemy when a collision pulse coincides with that enemy being drawn, and speeds up as enemies die. It sits in the VGA object pipeline and feeds the enemy bitmap (index plus offsets) and the game controller (status flags).

Parameters:
NUM_COLS, 6, enemies per row
NUM_ROWS, 3, rows in formation
INITIAL_X, 40, formation top-left X after reset/restart (pixels)
INITIAL_Y, 40, formation top-left Y after reset/restart (pixels)
OBJECT_WIDTH_X, 30, enemy width (pixels)
OBJECT_HEIGHT_Y, 30, enemy height (pixels)
GAP_X, 10, horizontal gap between enemies; PITCH_X = OBJECT_WIDTH_X + GAP_X
GAP_Y, 10, vertical gap between rows; PITCH_Y = OBJECT_HEIGHT_Y + GAP_Y
X_SPEED, 64, base horizontal speed per frame, fixed point (units of 1/64 pixel)
SPEEDUP_STEP, 8, fixed-point speed added per killed enemy
STEP_DOWN_Y, 16, pixels moved down on each bounce
SCREEN_WIDTH, 640, right screen limit (pixels)
BOTTOM_LIMIT, 440, Y at which the formation has landed
FIXED_POINT_MULTIPLIER, 64, fixed-point scale

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per frame
start  in  1  one-cycle pulse: begin or restart the wave
collision  in  1  hit pulse, qualified by the current drawingRequest
pixelX  in  11  current VGA pixel X
pixelY  in  11  current VGA pixel Y
drawingRequest  out  1  pixel is inside a live enemy
offsetX  out  11  pixel offset inside that enemy
offsetY  out  11  pixel offset inside that enemy
enemyIndex  out  $clog2(NUM_ROWS*NUM_COLS)  enemy being drawn, row*NUM_COLS+col
aliveCount  out  $clog2(NUM_ROWS*NUM_COLS+1)  number of live enemies
cleared  out  1  all enemies dead
landed  out  1  formation reached BOTTOM_LIMIT

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, X = INITIAL_X*FPM, Y = INITIAL_Y*FPM, dir=+1, alive mask all ones.
  - drawingRequest=0, offsetX/offsetY/enemyIndex=0, aliveCount=N, cleared=0, landed=0.
  - Reset asserted mid-frame takes effect immediately.
- States:
  - IDLE: start goes to MOVE.
  - MOVE: startOfFrame updates position. Last enemy killed goes to CLEARED. Bottom check met goes to LANDED.
  - CLEARED / LANDED: the formation is frozen. start reloads the reset values (except the state) and goes to MOVE.
  - cleared=1 exactly while in CLEARED; landed=1 exactly while in LANDED.
- Drawing, in every state including IDLE (one-cycle latency, registered like the single enemy):
  - relX = pixelX - X/FPM, relY = pixelY - Y/FPM.
  - col = relX/PITCH_X, row = relY/PITCH_Y. A per-column / per-row compare loop is acceptable in place of division.
  - A hit requires relX, relY >= 0; col < NUM_COLS; row < NUM_ROWS; relX mod PITCH_X < OBJECT_WIDTH_X; relY mod PITCH_Y < OBJECT_HEIGHT_Y; and the enemy's alive bit set.
  - On a hit, the next cycle has drawingRequest=1, offsetX = relX mod PITCH_X, offsetY = relY mod PITCH_Y, enemyIndex = row*NUM_COLS+col.
  - Otherwise the next cycle has drawingRequest=0 and offsetX/offsetY/enemyIndex=0.
  - Gaps and dead enemies never draw.
- Kill:
  - If collision=1 and drawingRequest=1 in the same cycle (MOVE only), alive[enemyIndex] is cleared on the next edge.
  - aliveCount is decremented on that same edge.
  - A repeat collision on an already-dead index has no effect; this cannot occur because drawingRequest is 0 for dead enemies.
- Speed = X_SPEED + (N - aliveCount)*SPEEDUP_STEP, computed in 32-bit signed arithmetic.
- Movement, on startOfFrame in MOVE:
  - Edges are taken over alive enemies only. L = leftmost alive column, R = rightmost alive column, B = lowest alive row.
  - Xn = X + dir*speed.
  - If dir=+1 and Xn/FPM + R*PITCH_X + OBJECT_WIDTH_X > SCREEN_WIDTH: X unchanged, dir=-1, Y += STEP_DOWN_Y*FPM.
  - Else if dir=-1 and Xn/FPM + L*PITCH_X < 0: X unchanged, dir=+1, Y += STEP_DOWN_Y*FPM.
  - Else X = Xn.
  - After any Y change: if Y/FPM + B*PITCH_Y + OBJECT_HEIGHT_Y >= BOTTOM_LIMIT, go to LANDED.
- Simultaneous events:
  - A kill and startOfFrame on the same edge: the kill applies, and movement uses the pre-kill mask and speed.
  - A kill of the last enemy on the same edge as startOfFrame: CLEARED takes priority over LANDED, and the position still updates.
  - start while in MOVE is ignored.
- Arithmetic widths: X/Y are 32-bit signed fixed point; division by FPM truncates toward zero; pixel-domain values are 11-bit signed.

Test Plan:
- Reset, then pixel (45,45) -> next cycle drawingRequest=1, offset (5,5), enemyIndex=0. Pixel (75,45) (gap) -> drawingRequest=0. Pixel (245,125) -> enemyIndex=17, offset (5,5).
- start, SPEEDUP_STEP=0, 370 frames -> X=410 px (right edge at 640, no bounce). Frame 371 -> X stays 410, Y=56, dir=-1. Next frame -> X=409.
- Collision while drawing enemyIndex=0 -> aliveCount=17 one cycle later, and pixel (45,45) no longer draws. Default speedup -> speed becomes 72/64 px per frame.
- Kill indices 5, 11, 17 (column 5), SPEEDUP_STEP=0, from X=410 moving right -> no bounce until the step that would take X past 450. Rows 0-1 only alive, Y crossing the bottom check at 330 -> no landing; landing then occurs at Y/FPM + 70 >= 440.
- Kill all 18 enemies, the last on the same cycle as startOfFrame -> cleared=1, landed=0, aliveCount=0. start -> alive mask full, X=40, Y=40, state MOVE.
- Assert reset mid-frame while in MOVE with kills done -> outputs immediately return to their reset values and state=IDLE. startOfFrame pulses in IDLE -> no movement.
